rk8je_xfer_seq: RTL and testbench
=================================

RK8JE_XFER_SEQ -- requirements
Module: rk8je_xfer_seq

Interface
REQ-001 Parameter SEEKCLKS, default 1000, CLOCK cycles spent in head-in-motion per seek or transfer start.
REQ-002 Parameter MAXCYL, default 202, highest legal cylinder number.
REQ-003 CLOCK  in  1  all state changes on rising edge.
REQ-004 RESET  in  1  synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; begin the function held on command/diskaddr/memaddr.
REQ-006 abort  in  1  one-cycle pulse; terminate any operation in progress.
REQ-007 command  in  12  [11:9] function, [7] done-on-seek, [6] half block, [5:3] memory field, [2:1] drive, [0] cylinder msb.
REQ-008 diskaddr  in  12  [11:5] cylinder low bits, [4] surface, [3:0] sector.
REQ-009 memaddr  in  12  starting memory address.
REQ-010 wrlock / notready  in  4 each  per-drive write-lock / not-ready flags.
REQ-011 busy  out  1  high from accepted start until finish/abort.
REQ-012 hdim  out  1  high while the seek timer runs.
REQ-013 stset  out  12  one-cycle pulse of status bits to OR into status (bit numbering as RK8JE status: 11 done, 9 xfer exceeded, 7 file not ready, 4 write lock, 0 cylinder error).
REQ-014 curaddr  out  12  running memory address; curaddr_we  out  1  pulse when it changes.
REQ-015 dmareq  out  1; dmawrite  out  1; dmaaddr  out  15; dmawdata  out  12; dmaack  in  1; dmardata  in  12  -- memory data-break port.
REQ-016 dskreq  out  1; dskwrite  out  1; dskaddr  out  23 {drive,cyl8,surface,sector,word8}; dskwdata  out  12; dskack  in  1; dskrdata  in  12  -- disk image port.

Function
REQ-017 Functions: 0 read, 1 read all, 4 write, 5 write all treated as read/read/write/write; 3 seek; 2, 6, 7 complete immediately with stset bit 11.
REQ-018 States: IDLE, CHECK, SEEK, DRD (disk read), MWR (memory write), MRD (memory read), DWR (disk write), FIN.
REQ-019 start ignored while busy; accepted start latches all inputs and enters CHECK next cycle, busy high same cycle.
REQ-020 CHECK, one cycle: notready[drive] -> stset bit 7, FIN; cylinder {cmd[0],diskaddr[11:5]} > MAXCYL -> stset bit 0, FIN; write to wrlock[drive] -> stset bit 4, FIN; otherwise SEEK. Priority in that order, only one error bit set.
REQ-021 SEEK: hdim high, counter loads SEEKCLKS-1, decrements to 0, then seek function -> FIN (stset bit 11 only if cmd[7]), read -> DRD, write -> MRD.
REQ-022 Word count 256, or 128 if cmd[6]; word index starts 0.
REQ-023 Request handshake (both ports): req, write, addr, data stable until the cycle ack is sampled high; req drops the cycle after ack; new request no earlier than next cycle.
REQ-024 Read loop: DRD fetch word -> MWR write it to dmaaddr {field,curaddr} -> curaddr+1, curaddr_we, index+1; repeat until count reached.
REQ-025 Write loop: MRD fetch word -> DWR write it -> curaddr+1, index+1; for half block, words 128..255 written to disk as 0000 without MRD, curaddr unchanged.
REQ-026 curaddr wraps 7777 -> 0000 within the same field; field never increments.
REQ-027 Transfer end: if sector==15 and surface==1 and cylinder==MAXCYL, no effect; transfer completion stset bit 11; if block number would exceed last block (never, single block) no bit 9 -- bit 9 set only when start requests function with sector field >15 impossible, so bit 9 reserved, never pulsed.
REQ-028 FIN, one cycle: drives stset, drops busy, returns IDLE; stset zero in every other cycle.
REQ-029 abort: any state -> IDLE next cycle, dmareq/dskreq/busy/hdim low, no stset; an ack arriving after abort ignored; abort and start same cycle: abort wins, start dropped.
REQ-030 dskaddr word field equals current index; cyl/surface/sector constant during a transfer.

Reset
REQ-031 RESET forces IDLE; busy, hdim, stset, curaddr_we, dmareq, dskreq, dmawrite, dskwrite low; curaddr, dmaaddr, dmawdata, dskaddr, dskwdata zero; overrides start/abort and any operation mid-transfer.

Verification
REQ-032 SEEKCLKS=4, read, cmd=0o0000, diskaddr=0o0021, memaddr=0o0200, acks after 1 cycle -> 256 disk reads then memory writes to 00200..00577, stset=0o4000 once, busy low after.
REQ-033 Write half block, cmd=0o4110 field 1, memaddr=0o7700 -> 128 memory reads at 17700..17777 then 10000..10077, disk words 128..255 written 0000, final curaddr=0o0100.
REQ-034 Write with wrlock[0]=1 -> no requests, hdim never high, stset=0o0020 in the cycle after CHECK.
REQ-035 cylinder 203 (cmd[0]=1, diskaddr[11:5]=0o113) -> stset=0o0001; with notready also set -> stset=0o0200 only.
REQ-036 Seek with cmd[7]=0 -> hdim high exactly SEEKCLKS cycles, busy drops, stset stays 0; with cmd[7]=1 -> stset=0o4000.
REQ-037 abort during MWR with dmaack stalled, then ack -> dmareq low next cycle, late ack ignored, no stset; new start accepted afterwards.

Source files
------------

// File: rtl/rk8je_xfer_seq_if.sv
// rk8je_xfer_seq_if: command, status, memory data-break and disk-image signals of the RK8JE transfer sequencer
// slave modport: the sequencer (i_* inputs, o_* outputs); master modport: controller, memory and disk side
interface rk8je_xfer_seq_if;
  logic        i_start;
  logic        i_abort;
  logic [11:0] i_command;
  logic [11:0] i_diskaddr;
  logic [11:0] i_memaddr;
  logic [3:0]  i_wrlock;
  logic [3:0]  i_notready;
  logic        o_busy;
  logic        o_hdim;
  logic [11:0] o_stset;
  logic [11:0] o_curaddr;
  logic        o_curaddr_we;
  logic        o_dmareq;
  logic        o_dmawrite;
  logic [14:0] o_dmaaddr;
  logic [11:0] o_dmawdata;
  logic        i_dmaack;
  logic [11:0] i_dmardata;
  logic        o_dskreq;
  logic        o_dskwrite;
  logic [22:0] o_dskaddr;
  logic [11:0] o_dskwdata;
  logic        i_dskack;
  logic [11:0] i_dskrdata;
  modport slave (
    input  i_start, i_abort, i_command, i_diskaddr, i_memaddr, i_wrlock, i_notready,
           i_dmaack, i_dmardata, i_dskack, i_dskrdata,
    output o_busy, o_hdim, o_stset, o_curaddr, o_curaddr_we,
           o_dmareq, o_dmawrite, o_dmaaddr, o_dmawdata,
           o_dskreq, o_dskwrite, o_dskaddr, o_dskwdata
  );
  modport master (
    output i_start, i_abort, i_command, i_diskaddr, i_memaddr, i_wrlock, i_notready,
           i_dmaack, i_dmardata, i_dskack, i_dskrdata,
    input  o_busy, o_hdim, o_stset, o_curaddr, o_curaddr_we,
           o_dmareq, o_dmawrite, o_dmaaddr, o_dmawdata,
           o_dskreq, o_dskwrite, o_dskaddr, o_dskwdata
  );
endinterface

// File: rtl/rk8je_xfer_seq.sv
// rk8je_xfer_seq: RK8JE function sequencer - checks, seek timing, block transfer between disk image and memory
// Ports: CLOCK, RESET (sync, active-high); bus (slave): start/abort/command/diskaddr/memaddr/wrlock/notready in,
// busy/hdim/stset/curaddr(+we) out, memory data-break port (dma*) and disk image port (dsk*).
module rk8je_xfer_seq #(
  parameter int SEEKCLKS = 1000,
  parameter int MAXCYL   = 202
) (
  input logic             CLOCK,
  input logic             RESET,
  rk8je_xfer_seq_if.slave bus
);
  localparam int CW = $clog2(SEEKCLKS + 1);
  typedef enum logic [2:0] {IDLE, CHECK, SEEK, DRD, MWR, MRD, DWR, FIN} state_t;
  state_t        r_state;
  logic [2:0]    r_fn, r_field;
  logic          r_dos, r_half, r_surf;
  logic [1:0]    r_drv;
  logic [7:0]    r_cyl, r_idx;
  logic [3:0]    r_sec, r_wl, r_nr;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_hdim, r_cawe, r_dmareq, r_dmawrite, r_dskreq, r_dskwrite;
  logic [11:0]   r_stset, r_curaddr, r_dmawdata, r_dskwdata;
  logic [14:0]   r_dmaaddr;
  logic [22:0]   r_dskaddr;
  logic          w_rd, w_wr, w_imm, w_last, w_zfill, w_unused;
  logic [7:0]    w_nidx;
  logic [11:0]   w_chk;
  assign w_rd    = r_fn[2:1] == 2'b00;
  assign w_wr    = r_fn[2:1] == 2'b10;
  assign w_imm   = !w_rd && !w_wr && r_fn != 3'd3;
  // reads of a half block stop at word 127; writes always cover the full 256-word block
  assign w_last  = r_idx == {~(r_half & w_rd), 7'h7f};
  assign w_nidx  = r_idx + 8'd1;
  assign w_zfill = r_half & w_nidx[7];
  assign w_unused = bus.i_command[8];
  assign w_chk   = w_imm ? 12'o4000 :
                   r_nr[r_drv] ? 12'o0200 :
                   r_cyl > 8'(MAXCYL) ? 12'o0001 :
                   (w_wr && r_wl[r_drv]) ? 12'o0020 : 12'o0000;
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_hdim     <= 1'b0;
      r_stset    <= '0;
      r_cawe     <= 1'b0;
      r_dmareq   <= 1'b0;
      r_dmawrite <= 1'b0;
      r_dskreq   <= 1'b0;
      r_dskwrite <= 1'b0;
      r_curaddr  <= '0;
      r_dmaaddr  <= '0;
      r_dmawdata <= '0;
      r_dskaddr  <= '0;
      r_dskwdata <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
    end else if (bus.i_abort) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_hdim   <= 1'b0;
      r_stset  <= '0;
      r_cawe   <= 1'b0;
      r_dmareq <= 1'b0;
      r_dskreq <= 1'b0;
    end else begin
      r_stset <= '0;
      r_cawe  <= 1'b0;
      case (r_state)
        IDLE: if (bus.i_start) begin
          r_fn      <= bus.i_command[11:9];
          r_dos     <= bus.i_command[7];
          r_half    <= bus.i_command[6];
          r_field   <= bus.i_command[5:3];
          r_drv     <= bus.i_command[2:1];
          r_cyl     <= {bus.i_command[0], bus.i_diskaddr[11:5]};
          r_surf    <= bus.i_diskaddr[4];
          r_sec     <= bus.i_diskaddr[3:0];
          r_curaddr <= bus.i_memaddr;
          r_wl      <= bus.i_wrlock;
          r_nr      <= bus.i_notready;
          r_idx     <= '0;
          r_busy    <= 1'b1;
          r_state   <= CHECK;
        end
        CHECK: begin
          r_stset <= w_chk;
          r_hdim  <= w_chk == 12'o0000;
          r_cnt   <= CW'(SEEKCLKS - 1);
          r_state <= w_chk != 12'o0000 ? FIN : SEEK;
        end
        SEEK: if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        else begin
          r_hdim  <= 1'b0;
          r_stset <= (!w_rd && !w_wr && r_dos) ? 12'o4000 : 12'o0000;
          r_state <= w_rd ? DRD : w_wr ? MRD : FIN;
        end
        // each transfer state enters with its request low, raises it, then waits for the ack
        DRD: if (!r_dskreq) begin
          r_dskreq   <= 1'b1;
          r_dskwrite <= 1'b0;
          r_dskaddr  <= {r_drv, r_cyl, r_surf, r_sec, r_idx};
        end else if (bus.i_dskack) begin
          r_dskreq   <= 1'b0;
          r_dmawdata <= bus.i_dskrdata;
          r_state    <= MWR;
        end
        MWR: if (!r_dmareq) begin
          r_dmareq   <= 1'b1;
          r_dmawrite <= 1'b1;
          r_dmaaddr  <= {r_field, r_curaddr};
        end else if (bus.i_dmaack) begin
          r_dmareq  <= 1'b0;
          r_curaddr <= r_curaddr + 12'd1;
          r_cawe    <= 1'b1;
          r_idx     <= w_nidx;
          r_stset   <= w_last ? 12'o4000 : 12'o0000;
          r_state   <= w_last ? FIN : DRD;
        end
        MRD: if (!r_dmareq) begin
          r_dmareq   <= 1'b1;
          r_dmawrite <= 1'b0;
          r_dmaaddr  <= {r_field, r_curaddr};
        end else if (bus.i_dmaack) begin
          r_dmareq   <= 1'b0;
          r_dskwdata <= bus.i_dmardata;
          r_curaddr  <= r_curaddr + 12'd1;
          r_cawe     <= 1'b1;
          r_state    <= DWR;
        end
        // second half of a half-block write pads with zeros and never touches memory
        DWR: if (!r_dskreq) begin
          r_dskreq   <= 1'b1;
          r_dskwrite <= 1'b1;
          r_dskaddr  <= {r_drv, r_cyl, r_surf, r_sec, r_idx};
        end else if (bus.i_dskack) begin
          r_dskreq   <= 1'b0;
          r_idx      <= w_nidx;
          r_dskwdata <= '0;
          r_stset    <= w_last ? 12'o4000 : 12'o0000;
          r_state    <= w_last ? FIN : w_zfill ? DWR : MRD;
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.o_busy       = r_busy;
  assign bus.o_hdim       = r_hdim;
  assign bus.o_stset      = r_stset;
  assign bus.o_curaddr    = r_curaddr;
  assign bus.o_curaddr_we = r_cawe;
  assign bus.o_dmareq     = r_dmareq;
  assign bus.o_dmawrite   = r_dmawrite;
  assign bus.o_dmaaddr    = r_dmaaddr;
  assign bus.o_dmawdata   = r_dmawdata;
  assign bus.o_dskreq     = r_dskreq;
  assign bus.o_dskwrite   = r_dskwrite;
  assign bus.o_dskaddr    = r_dskaddr;
  assign bus.o_dskwdata   = r_dskwdata;
endmodule

// File: tb/tb_rk8je_xfer_seq.sv
// tb_rk8je_xfer_seq: directed stimulus with a queue of expected transactions checked by a monitor
module tb_rk8je_xfer_seq;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;
  rk8je_xfer_seq_if bus();
  rk8je_xfer_seq #(.SEEKCLKS(4), .MAXCYL(202)) dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));

  typedef struct packed {
    logic [1:0]  kind;
    logic        wr;
    logic [22:0] addr;
    logic [11:0] data;
  } ev_t;
  ev_t q[$];
  int vectors = 0, miscompares = 0, hdim_cnt = 0, cyc = 0, start_cyc = 0, stset_cyc = 0;
  logic dma_stall = 1'b0, late_ack = 1'b0;

  function automatic logic [11:0] dsk_data(logic [22:0] a);
    return a[11:0] ^ 12'o5252;
  endfunction
  function automatic logic [11:0] mem_data(logic [14:0] a);
    return a[11:0] ^ {a[14:12], 9'o123};
  endfunction
  function automatic void push(logic [1:0] k, logic w, logic [22:0] a, logic [11:0] d);
    q.push_back({k, w, a, d});
  endfunction

  task automatic chk(string name, logic [22:0] act, logic [22:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0o, required %0o", name, act, exp);
    end
  endtask

  task automatic observe(logic [1:0] k, logic w, logic [22:0] a, logic [11:0] d);
    ev_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected kind=%0d wr=%0b addr=%0o data=%0o at cycle %0d, required no event", k, w, a, d, cyc);
    end else begin
      e = q.pop_front();
      if (k !== e.kind || w !== e.wr || a !== e.addr || ((e.kind == 2'd2 || e.wr) && d !== e.data)) begin
        miscompares++;
        $display("FAIL event: got kind=%0d wr=%0b addr=%0o data=%0o, required kind=%0d wr=%0b addr=%0o data=%0o",
                 k, w, a, d, e.kind, e.wr, e.addr, e.data);
      end
    end
  endtask

  always @(posedge CLOCK) cyc <= cyc + 1;

  always @(negedge CLOCK) if (!RESET) begin
    if (bus.o_hdim) hdim_cnt++;
    if (bus.o_dskreq && bus.i_dskack) observe(2'd0, bus.o_dskwrite, bus.o_dskaddr, bus.o_dskwdata);
    if (bus.o_dmareq && bus.i_dmaack) observe(2'd1, bus.o_dmawrite, {8'd0, bus.o_dmaaddr}, bus.o_dmawdata);
    if (bus.o_stset != 12'd0) begin
      stset_cyc = cyc;
      observe(2'd2, 1'b0, 23'd0, bus.o_stset);
    end
  end

  initial begin
    bus.i_dskack = 1'b0; bus.i_dskrdata = '0;
    bus.i_dmaack = 1'b0; bus.i_dmardata = '0;
    forever begin
      @(posedge CLOCK); #1;
      if (bus.i_dskack) bus.i_dskack = 1'b0;
      else if (bus.o_dskreq) begin
        bus.i_dskack = 1'b1;
        bus.i_dskrdata = dsk_data(bus.o_dskaddr);
      end
      if (bus.i_dmaack) bus.i_dmaack = 1'b0;
      else if (bus.o_dmareq && !dma_stall) begin
        bus.i_dmaack = 1'b1;
        bus.i_dmardata = mem_data(bus.o_dmaaddr);
      end else if (late_ack) begin
        bus.i_dmaack = 1'b1;
        late_ack = 1'b0;
      end
    end
  end

  task automatic start_op(logic [11:0] cmd, logic [11:0] da, logic [11:0] ma, logic [3:0] wl, logic [3:0] nr);
    hdim_cnt = 0;
    @(posedge CLOCK); #1;
    bus.i_command = cmd; bus.i_diskaddr = da; bus.i_memaddr = ma;
    bus.i_wrlock = wl; bus.i_notready = nr; bus.i_start = 1'b1;
    @(posedge CLOCK); #1;
    bus.i_start = 1'b0;
    start_cyc = cyc;
    chk("busy_on_start", bus.o_busy, 1);
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while ((bus.o_busy || q.size() != 0) && n < bound) begin
      @(posedge CLOCK); #1;
      n++;
    end
    vectors++;
    if (n >= bound) begin
      miscompares++;
      $display("FAIL timeout: busy=%0b queued=%0d, required idle with empty queue", bus.o_busy, q.size());
      q.delete();
    end
    repeat (2) @(posedge CLOCK);
    #1;
  endtask

  initial begin
    logic [11:0] ma;
    logic [22:0] da;
    int n;
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_command = '0; bus.i_diskaddr = '0;
    bus.i_memaddr = '0; bus.i_wrlock = '0; bus.i_notready = '0;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_hdim", bus.o_hdim, 0);
    chk("rst_stset", bus.o_stset, 0);
    chk("rst_dmareq", bus.o_dmareq, 0);
    chk("rst_dskreq", bus.o_dskreq, 0);
    chk("rst_curaddr", bus.o_curaddr, 0);
    chk("rst_dskaddr", bus.o_dskaddr, 0);
    RESET = 1'b0;

    for (int i = 0; i < 256; i++) begin
      da = {2'd0, 8'd0, 1'b1, 4'd1, 8'(i)};
      push(2'd0, 1'b0, da, 12'd0);
      push(2'd1, 1'b1, {8'd0, 3'd0, 12'o0200 + 12'(i)}, dsk_data(da));
    end
    push(2'd2, 1'b0, 23'd0, 12'o4000);
    start_op(12'o0000, 12'o0021, 12'o0200, 4'd0, 4'd0);
    wait_idle(5000);
    chk("read_hdim_cycles", 23'(hdim_cnt), 4);
    chk("read_curaddr", bus.o_curaddr, 12'o0600);

    for (int i = 0; i < 256; i++) begin
      ma = 12'o7700 + 12'(i);
      da = {2'd0, 8'd2, 1'b0, 4'd5, 8'(i)};
      if (i < 128) begin
        push(2'd1, 1'b0, {8'd0, 3'd1, ma}, 12'd0);
        push(2'd0, 1'b1, da, mem_data({3'd1, ma}));
      end else push(2'd0, 1'b1, da, 12'o0000);
    end
    push(2'd2, 1'b0, 23'd0, 12'o4000);
    start_op(12'o4110, 12'o0105, 12'o7700, 4'd0, 4'd0);
    wait_idle(5000);
    chk("half_curaddr", bus.o_curaddr, 12'o0100);

    push(2'd2, 1'b0, 23'd0, 12'o0020);
    start_op(12'o4000, 12'o0000, 12'o0000, 4'b0001, 4'd0);
    wait_idle(100);
    chk("wrlock_stset_cycle", 23'(stset_cyc - start_cyc), 1);
    chk("wrlock_hdim_cycles", 23'(hdim_cnt), 0);

    push(2'd2, 1'b0, 23'd0, 12'o0001);
    start_op(12'o0001, 12'o4540, 12'o0000, 4'd0, 4'd0);
    wait_idle(100);
    push(2'd2, 1'b0, 23'd0, 12'o0200);
    start_op(12'o0001, 12'o4540, 12'o0000, 4'd0, 4'b0001);
    wait_idle(100);

    start_op(12'o3000, 12'o0000, 12'o0000, 4'd0, 4'd0);
    wait_idle(100);
    chk("seek_hdim_cycles", 23'(hdim_cnt), 4);
    push(2'd2, 1'b0, 23'd0, 12'o4000);
    start_op(12'o3200, 12'o0000, 12'o0000, 4'd0, 4'd0);
    wait_idle(100);
    chk("seek_done_hdim_cycles", 23'(hdim_cnt), 4);

    dma_stall = 1'b1;
    push(2'd0, 1'b0, 23'd0, 12'd0);
    start_op(12'o0000, 12'o0000, 12'o1000, 4'd0, 4'd0);
    n = 0;
    while (!bus.o_dmareq && n < 100) begin
      @(posedge CLOCK); #1;
      n++;
    end
    chk("abort_reached_mwr", bus.o_dmareq, 1);
    repeat (2) @(posedge CLOCK);
    #1;
    bus.i_abort = 1'b1;
    @(posedge CLOCK); #1;
    bus.i_abort = 1'b0;
    chk("abort_dmareq", bus.o_dmareq, 0);
    chk("abort_busy", bus.o_busy, 0);
    late_ack = 1'b1;
    repeat (4) @(posedge CLOCK);
    #1;
    dma_stall = 1'b0;
    chk("abort_queue_left", 23'(q.size()), 0);
    push(2'd2, 1'b0, 23'd0, 12'o4000);
    start_op(12'o2000, 12'o0000, 12'o0000, 4'd0, 4'd0);
    wait_idle(100);

    @(posedge CLOCK); #1;
    bus.i_command = 12'o0000; bus.i_start = 1'b1; bus.i_abort = 1'b1;
    @(posedge CLOCK); #1;
    bus.i_start = 1'b0; bus.i_abort = 1'b0;
    chk("abort_start_busy", bus.o_busy, 0);
    repeat (10) @(posedge CLOCK);
    #1;
    chk("abort_start_dskreq", bus.o_dskreq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
